// File: rtl/aes_word_host.sv
// aes_word_host
//   Host-side initiator for the AES core's 32-bit word interface. It takes one
//   128-bit block, a 128-bit key and a mode from a local requester. It sends
//   them to the core as four ld word beats, MSW first. It then collects four
//   done/text_out beats, also MSW first, into a single 128-bit response.
//
//   Optional feature: define AES_HOST_TIMEOUT_EN to build a WAIT-state watchdog.
//   The watchdog gives up after TIMEOUT_CYCLES cycles without a done beat. It
//   then pulses err and returns to IDLE. Without the macro, WAIT waits forever
//   and TIMEOUT_CYCLES is ignored.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   req_valid/ready : request handshake; ready only in IDLE and not in reset
//   req_text/key    : 128-bit block and key
//   req_mode        : 0 = encrypt, 1 = decrypt
//   req_new_key     : decrypt only; request key expansion (kld)
//   rsp_valid/ready : response handshake; rsp_data is held while valid
//   err             : one-cycle pulse on a protocol error or timeout
//   ld, kld, mode   : core strobes and mode (registered)
//   key, text_in    : 32-bit words to the core (registered)
//   done, text_out  : result-word strobe and word from the core
module aes_word_host #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_text,
  input  logic [127:0] req_key,
  input  logic         req_mode,
  input  logic         req_new_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         err,
  output logic         ld,
  output logic         kld,
  output logic         mode,
  output logic [31:0]  key,
  output logic [31:0]  text_in,
  input  logic         done,
  input  logic [31:0]  text_out
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic [127:0]  text_reg, text_next;
  logic [127:0]  key_reg, key_next;
  logic          new_key_reg, new_key_next;
  logic          ld_reg, ld_next;
  logic          kld_reg, kld_next;
  logic          mode_reg, mode_next;
  logic [31:0]   key_out_reg, key_out_next;
  logic [31:0]   text_in_reg, text_in_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [127:0]  rsp_data_reg, rsp_data_next;
  logic          err_reg, err_next;
  // Result beats 0..2 collect here. Beat 3 goes straight into rsp_data.
  logic [95:0]   buf_reg, buf_next;
  logic [1:0]    beat_nxt;

  // Word view of the latched block, index 0 = MSW.
  logic [31:0]   text_words [4];
  logic [31:0]   key_words  [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign text_words[gi] = text_reg[127 - 32*gi -: 32];
    assign key_words[gi]  = key_reg[127 - 32*gi -: 32];
  end

  assign beat_nxt  = cnt_reg + 2'd1;
  assign req_ready = (state_reg == IDLE) && !rst;

  assign ld        = ld_reg;
  assign kld       = kld_reg;
  assign mode      = mode_reg;
  assign key       = key_out_reg;
  assign text_in   = text_in_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign err       = err_reg;

`ifdef AES_HOST_TIMEOUT_EN
  logic [31:0] tmo_reg, tmo_next;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    text_next      = text_reg;
    key_next       = key_reg;
    new_key_next   = new_key_reg;
    ld_next        = ld_reg;
    kld_next       = kld_reg;
    mode_next      = mode_reg;
    key_out_next   = key_out_reg;
    text_in_next   = text_in_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    buf_next       = buf_reg;
    err_next       = 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
    tmo_next       = tmo_reg;
`endif

    case (state_reg)
      IDLE: begin
        // A stray result word is reported and dropped.
        if (done) err_next = 1'b1;
        if (req_valid) begin
          text_next    = req_text;
          key_next     = req_key;
          new_key_next = req_new_key;
          mode_next    = req_mode;
          cnt_next     = 2'd0;
          // Beat 0 leaves on the next cycle, so take it from the request directly.
          ld_next      = 1'b1;
          kld_next     = req_mode & req_new_key;
          key_out_next = req_key[127:96];
          text_in_next = req_text[127:96];
          state_next   = SEND;
        end
      end

      SEND: begin
        if (done) err_next = 1'b1;
        if (cnt_reg == 2'd3) begin
          // The word outputs keep beat 3 through WAIT.
          ld_next    = 1'b0;
          kld_next   = 1'b0;
          cnt_next   = 2'd0;
          state_next = WAIT;
`ifdef AES_HOST_TIMEOUT_EN
          tmo_next   = 32'd0;
`endif
        end else begin
          cnt_next     = beat_nxt;
          kld_next     = mode_reg & new_key_reg;
          key_out_next = key_words[beat_nxt];
          text_in_next = text_words[beat_nxt];
        end
      end

      WAIT: begin
        if (done) begin
          buf_next[95:64] = text_out;
          cnt_next        = 2'd1;
          state_next      = RECV;
        end
`ifdef AES_HOST_TIMEOUT_EN
        else if (tmo_reg == 32'(TIMEOUT_CYCLES - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + 32'd1;
        end
`endif
      end

      RECV: begin
        if (done) begin
          case (cnt_reg)
            2'd1: buf_next[63:32] = text_out;
            2'd2: buf_next[31:0]  = text_out;
            default: ;
          endcase
          if (cnt_reg == 2'd3) begin
            rsp_data_next  = {buf_reg, text_out};
            rsp_valid_next = 1'b1;
            cnt_next       = 2'd0;
            state_next     = HOLD;
          end else begin
            cnt_next = beat_nxt;
          end
        end else begin
          // Burst broke early: report it and drop the partial result.
          err_next   = 1'b1;
          buf_next   = '0;
          cnt_next   = 2'd0;
          state_next = IDLE;
        end
      end

      HOLD: begin
        if (done) err_next = 1'b1;
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 2'd0;
      text_reg      <= '0;
      key_reg       <= '0;
      new_key_reg   <= 1'b0;
      ld_reg        <= 1'b0;
      kld_reg       <= 1'b0;
      mode_reg      <= 1'b0;
      key_out_reg   <= '0;
      text_in_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      buf_reg       <= '0;
      err_reg       <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
      tmo_reg       <= 32'd0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      text_reg      <= text_next;
      key_reg       <= key_next;
      new_key_reg   <= new_key_next;
      ld_reg        <= ld_next;
      kld_reg       <= kld_next;
      mode_reg      <= mode_next;
      key_out_reg   <= key_out_next;
      text_in_reg   <= text_in_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      buf_reg       <= buf_next;
      err_reg       <= err_next;
`ifdef AES_HOST_TIMEOUT_EN
      tmo_reg       <= tmo_next;
`endif
    end
  end

endmodule

// File: tb/tb_aes_word_host.sv
module tb_aes_word_host;

  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam int B_NORMAL = 0;
  localparam int B_BROKEN = 1;
  localparam int B_NONE   = 2;
  localparam int B_RESET  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] req_text = '0;
  logic [127:0] req_key = '0;
  logic         req_mode = 1'b0;
  logic         req_new_key = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [127:0] rsp_data;
  logic         err;
  logic         ld;
  logic         kld;
  logic         mode;
  logic [31:0]  key;
  logic [31:0]  text_in;
  logic         done = 1'b0;
  logic [31:0]  text_out = '0;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int exp_err = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_word_host #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_text(req_text), .req_key(req_key),
    .req_mode(req_mode), .req_new_key(req_new_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err(err), .ld(ld), .kld(kld), .mode(mode),
    .key(key), .text_in(text_in),
    .done(done), .text_out(text_out)
  );

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Core model result: FIPS-197 vectors for the known key, otherwise a
  // simple reversible scramble so every data bit reaches the response.
  function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k, input logic m);
    if (k == FK && !m && t == FPT) return FCT;
    if (k == FK && m && t == FCT) return FPT;
    return {t[63:0], t[127:64]} ^ k ^ {128{m}};
  endfunction

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, 0);
    check("rst_ld", ld, 0);
    check("rst_kld", kld, 0);
    check("rst_mode", mode, 0);
    check("rst_key", key, 0);
    check("rst_text_in", text_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", err, 0);
  endtask

  task automatic do_txn(input logic [127:0] t, input logic [127:0] k, input logic m,
                        input logic nk, input int behav, input int bp);
    logic [31:0]  cap_t [4];
    logic [31:0]  cap_k [4];
    logic         cap_m;
    logic [127:0] core_res;
    logic [127:0] held;
    logic [127:0] exp;
    int           n;
    int           nb;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid   = 1'b1;
    req_text    = t;
    req_key     = k;
    req_mode    = m;
    req_new_key = nk;
    rsp_ready   = (bp == 0);
    if (behav == B_NORMAL) exp_q.push_back(core_fn(t, k, m));
    @(negedge clk);
    req_valid = 1'b0;
    req_text  = ~t;
    req_key   = ~k;
    req_mode  = ~m;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("ld_b%0d", b), ld, 1);
      check($sformatf("text_in_b%0d", b), text_in, t[127 - 32*b -: 32]);
      check($sformatf("key_b%0d", b), key, k[127 - 32*b -: 32]);
      check($sformatf("kld_b%0d", b), kld, m & nk);
      check($sformatf("mode_b%0d", b), mode, m);
      if (b == 0) check("req_ready_busy", req_ready, 0);
      cap_t[b] = text_in;
      cap_k[b] = key;
      cap_m    = mode;
      if (behav == B_RESET && b == 2) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_rst", req_ready, 1);
        return;
      end
      @(negedge clk);
    end
    check("ld_off", ld, 0);
    check("kld_off", kld, 0);
    check("text_in_hold", text_in, t[31:0]);
    if (behav == B_NONE) begin
`ifdef AES_HOST_TIMEOUT_EN
      n = 0;
      while (err !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", n, 16);
      check("req_ready_after_tmo", req_ready, 1);
      exp_err++;
      @(negedge clk);
`endif
      return;
    end
    repeat (3) @(negedge clk);
    core_res = core_fn({cap_t[0], cap_t[1], cap_t[2], cap_t[3]},
                       {cap_k[0], cap_k[1], cap_k[2], cap_k[3]}, cap_m);
    nb = (behav == B_BROKEN) ? 2 : 4;
    for (int b = 0; b < nb; b++) begin
      done     = 1'b1;
      text_out = core_res[127 - 32*b -: 32];
      @(negedge clk);
    end
    done     = 1'b0;
    text_out = '0;
    if (behav == B_BROKEN) begin
      @(negedge clk);
      exp_err++;
      check("err_broken", err, 1);
      check("rsp_valid_broken", rsp_valid, 0);
      check("req_ready_after_err", req_ready, 1);
      @(negedge clk);
      check("err_one_pulse", err, 0);
      check("rsp_valid_after_broken", rsp_valid, 0);
      return;
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", n, 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check("rsp_data", rsp_data, exp);
      $display("txn text=%h key=%h mode=%0d rsp=%h", t, k, m, rsp_data);
    end
    held = rsp_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_rsp_stable", rsp_data, held);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid_cleared", rsp_valid, 0);
    check("req_ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    logic [127:0] rt, rk;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_post_rst", req_ready, 1);

    do_txn(FPT, FK, 1'b0, 1'b0, B_NORMAL, 0);
    do_txn(FCT, FK, 1'b1, 1'b1, B_NORMAL, 0);

    rt = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    do_txn(rt, rk, 1'b1, 1'b0, B_NORMAL, 10);

    // Stray done in IDLE: err pulse, state unchanged.
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    exp_err++;
    check("err_stray_done", err, 1);
    check("req_ready_stray_done", req_ready, 1);

    rt = {$urandom, $urandom, $urandom, $urandom};
    do_txn(rt, rk, 1'b1, 1'b1, B_BROKEN, 0);

    rt = {$urandom, $urandom, $urandom, $urandom};
    do_txn(rt, rk, 1'b1, 1'b0, B_RESET, 0);

    rt = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    do_txn(rt, rk, 1'b0, 1'b1, B_NORMAL, 0);

`ifdef AES_HOST_TIMEOUT_EN
    do_txn(rt, rk, 1'b0, 1'b0, B_NONE, 0);
    do_txn(FPT, FK, 1'b0, 1'b0, B_NORMAL, 0);
`endif

    repeat (2) @(negedge clk);
    check("err_pulse_total", err_cnt, exp_err);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_word_host.md
# aes_word_host

Host-side initiator for the AES core's 32-bit word interface. It accepts one 128-bit block plus 128-bit key and mode from a local requester, serialises them into four `ld` word beats toward the core, then collects the four `done`/`text_out` result beats back into a 128-bit response. It sits between a system-side block producer and the AES core top, and owns the core's word-level load/collect protocol.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum cycles from the last `ld` beat to the first `done` beat (used only with `AES_HOST_TIMEOUT_EN`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_text` input 128: plaintext or ciphertext.
- `req_key` input 128: key.
- `req_mode` input 1: 0 = encrypt, 1 = decrypt.
- `req_new_key` input 1: decrypt only; requests key expansion (`kld`).
- `rsp_valid` output 1: result held.
- `rsp_ready` input 1: consumer accepts result.
- `rsp_data` output 128: result block.
- `err` output 1: one-cycle pulse on a protocol error or timeout.
- `ld` output 1: word-load strobe to the core.
- `kld` output 1: key-load strobe to the core.
- `mode` output 1: mode to the core.
- `key` output 32: key word to the core.
- `text_in` output 32: text word to the core.
- `done` input 1: result-word strobe from the core.
- `text_out` input 32: result word from the core.

## Operation
- Word order is MSW first. Beat 0 carries bits [127:96] and beat 3 carries bits [31:0]. The same order applies to both directions.
- FSM states: IDLE, SEND, WAIT, RECV, HOLD.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, latch `req_text`, `req_key`, `req_mode`, `req_new_key`, clear the beat counter, go to SEND.
- SEND:
  - `ld` = 1 for exactly 4 consecutive cycles, with `key`/`text_in` = beat[n].
  - `kld` = `ld` when the latched mode = 1 and `req_new_key` = 1; otherwise `kld` = 0.
  - After beat 3, go to WAIT.
- WAIT:
  - `ld`, `kld` = 0 and the key/text outputs hold their last value.
  - On the first `done`, capture `text_out` as beat 0 and go to RECV.
- RECV:
  - Capture beats 1–3 on consecutive `done` cycles.
  - After beat 3, go to HOLD.
  - If `done` deasserts before 4 beats, pulse `err`, discard the partial data, return to IDLE.
- HOLD:
  - `rsp_valid` = 1 and `rsp_data` is stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
- `mode` is driven from the latched mode from SEND through HOLD. In IDLE it holds its last value.
- `done` seen in IDLE, SEND or HOLD: pulse `err` and drop the word; the state does not change.
- The beat counter is 2 bits and wraps 3→0 only at state exits.

## Timing
- Reset values:
  - `req_ready` = 0 while `rst` is high and 1 in the first cycle after `rst` deasserts.
  - `rsp_valid`, `err`, `ld`, `kld`, `mode` = 0.
  - `key`, `text_in`, `rsp_data` = 0.
  - State = IDLE.
- `rst` asserted mid-transaction aborts it: no `err`, no response, and outputs return to reset values on the next edge.
- All outputs to the core and the response are registered, except `req_ready`, which is decoded from state.
- Request accepted at edge T: `ld` is high during cycles T+1 through T+4.
- `done` beat 3 sampled at edge R: `rsp_valid` = 1 from R+1.
- Back-to-back throughput:
  - `rsp_ready` held high: `req_ready` returns 1 in the cycle after the response handshake.
  - Minimum spacing between request accepts is 4 + core latency + 4 + 2 cycles.
- `req_ready` is 0 in every state other than IDLE, so no request is accepted while one is in flight.

## Configuration
- `AES_HOST_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If it reaches `TIMEOUT_CYCLES` with no `done`, pulse `err` and return to IDLE.
  - The counter clears on entry to WAIT.
- `AES_HOST_TIMEOUT_EN` undefined:
  - No counter is built and `TIMEOUT_CYCLES` is ignored.
  - WAIT waits indefinitely.

## Test plan
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, mode 0.
  - `ld` beats 00112233, 44556677, 8899aabb, ccddeeff with `kld` = 0.
  - With a core model, `rsp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt with the same key, mode 1, `req_new_key` = 1, text 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `kld` is high on all 4 `ld` cycles.
  - `rsp_data` = 00112233445566778899aabbccddeeff.
- Backpressure: `rsp_ready` = 0 for 10 cycles after `rsp_valid`.
  - `rsp_data` is stable throughout and `req_ready` stays 0.
  - Accept occurs on the cycle `rsp_ready` rises, and `req_ready` = 1 on the next cycle.
- Broken result burst: `done` high for 2 cycles, then low.
  - `err` pulses once, there is no `rsp_valid`, and the block returns to IDLE.
- Timeout with `AES_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16: no `done` ever arrives.
  - `err` pulses 16 cycles after entering WAIT, then `req_ready` = 1.
- Reset mid-SEND: assert `rst` at beat 2.
  - Next cycle `ld` = 0 and all outputs are at reset values.
  - A fresh request afterwards completes correctly.
